// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter: FSM states, port-owner encoding,
// default bus widths and a small owner helper.
package arbiter_types;

    localparam int unsigned DEFAULT_LINE_W = 256;
    localparam int unsigned DEFAULT_ADDR_W = 32;
    localparam int unsigned DEFAULT_CNT_W  = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // The requester that wins a tie: whoever was not granted last.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bundle of the icache, dcache and memory-adaptor line buses around the arbiter.
//   master : arbiter view (takes cache requests, drives the adaptor request)
//   slave  : environment view (caches and adaptor)
interface cacheline_arbiter_if
    import arbiter_types::*;
#(
    parameter int unsigned LINE_W = DEFAULT_LINE_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);

    // icache side
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    // dcache side
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    // cacheline adaptor side
    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_resp;

    modport master (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output m_read, m_write, m_addr, m_wdata,
        input  m_rdata, m_resp
    );

    modport slave (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  m_read, m_write, m_addr, m_wdata,
        output m_rdata, m_resp
    );

endinterface

// File: rtl/cacheline_arbiter_sat_counter.sv
// Saturating up-counter used for the arbiter performance counters.
//   clk, rst (async active-low), inc : count one when high
//   count                            : registered value, sticks at all-ones
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between icache and dcache.
//   clk, rst (async active-low)
//   bus        : icache / dcache request+response, adaptor request+response
//   cnt_igrant : icache grants, saturating
//   cnt_dgrant : dcache grants, saturating
//   cnt_wait   : cycles a cache waits on the other (busy port or lost tie)
module cacheline_arbiter
    import arbiter_types::*;
#(
    parameter int unsigned LINE_W = DEFAULT_LINE_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    cacheline_arbiter_if.master bus,
    output logic [CNT_W-1:0]    cnt_igrant,
    output logic [CNT_W-1:0]    cnt_dgrant,
    output logic [CNT_W-1:0]    cnt_wait
);

    arb_state_e        state_q, state_d;
    owner_e            last_q, last_d;

    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [LINE_W-1:0] m_wdata_q, m_wdata_d;

    logic              i_req, d_req;
    logic              grant_i, grant_d;
    logic              inc_wait;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    // Read data is broadcast; only the resp strobe identifies the owner.
    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;

    assign bus.m_read  = m_read_q;
    assign bus.m_write = m_write_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;

    // State and downstream request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB_IDLE;
            last_q    <= OWN_I;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    // Arbitration, request launch and response routing.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        m_read_d   = m_read_q;
        m_write_d  = m_write_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        inc_wait   = 1'b0;
        bus.i_resp = 1'b0;
        bus.d_resp = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (i_req && d_req) begin
                    // Tie: the loser of this cycle is counted as waiting.
                    grant_d  = (other_owner(last_q) == OWN_D);
                    grant_i  = ~grant_d;
                    inc_wait = 1'b1;
                end else begin
                    grant_i = i_req;
                    grant_d = d_req;
                end

                if (grant_i) begin
                    m_read_d  = 1'b1;
                    m_write_d = 1'b0;
                    m_addr_d  = bus.i_addr;
                    last_d    = OWN_I;
                    state_d   = ARB_SERVE_I;
                end else if (grant_d) begin
                    // Simultaneous read and write from dcache resolves to the write.
                    m_read_d  = ~bus.d_write;
                    m_write_d = bus.d_write;
                    m_addr_d  = bus.d_addr;
                    if (bus.d_write) begin
                        m_wdata_d = bus.d_wdata;
                    end
                    last_d    = OWN_D;
                    state_d   = ARB_SERVE_D;
                end
            end

            ARB_SERVE_I: begin
                inc_wait = d_req;
                if (bus.m_resp) begin
                    bus.i_resp = 1'b1;
                    m_read_d   = 1'b0;
                    m_write_d  = 1'b0;
                    state_d    = ARB_IDLE;
                end
            end

            ARB_SERVE_D: begin
                inc_wait = i_req;
                if (bus.m_resp) begin
                    bus.d_resp = 1'b1;
                    m_read_d   = 1'b0;
                    m_write_d  = 1'b0;
                    state_d    = ARB_IDLE;
                end
            end

            default: begin
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
                state_d   = ARB_IDLE;
            end
        endcase
    end

    sat_counter #(.WIDTH(CNT_W)) u_cnt_igrant (
        .clk   (clk),
        .rst   (rst),
        .inc   (grant_i),
        .count (cnt_igrant)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cnt_dgrant (
        .clk   (clk),
        .rst   (rst),
        .inc   (grant_d),
        .count (cnt_dgrant)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cnt_wait (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_wait),
        .count (cnt_wait)
    );

    // A read and a write are never launched together.
    a_one_op: assert property (@(posedge clk) disable iff (!rst)
        !(m_read_q && m_write_q));

    // While a transaction is outstanding the downstream request is frozen.
    a_hold: assert property (@(posedge clk) disable iff (!rst)
        ((state_q != ARB_IDLE) && !bus.m_resp) |=>
            ($stable(m_addr_q) && $stable(m_wdata_q) && $stable({m_read_q, m_write_q})));

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter with a response scoreboard and an
// adaptor model that answers a fixed number of cycles after seeing a request.
module tb_cacheline_arbiter;
    import arbiter_types::*;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [CW-1:0] cnt_igrant, cnt_dgrant, cnt_wait;

    cacheline_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

    cacheline_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cnt_igrant (cnt_igrant),
        .cnt_dgrant (cnt_dgrant),
        .cnt_wait   (cnt_wait)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        owner_e        who;
        logic [LW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   mem_lat;
    int   mcnt;
    int   spur_req;
    int   spur_done;
    int   n;

    logic [LW-1:0] w1;
    logic [LW-1:0] w2;

    // Line returned by the adaptor model for a given address.
    function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
        if (a == 32'h0000_0060) return {(LW/8){8'hAA}};
        return {(LW/AW){a ^ 32'h5A5A_0000}};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input owner_e w, input logic [AW-1:0] a);
        exp_q.push_back('{w, line_for(a)});
    endtask

    // Count negedges until the selected resp is seen (bounded).
    task automatic wait_resp(input bit is_d, output int cnt);
        logic got;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 50) begin
            @(negedge clk);
            cnt++;
            got = is_d ? (bus.d_resp === 1'b1) : (bus.i_resp === 1'b1);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no resp within %0d cycles", is_d ? "d_resp" : "i_resp", cnt);
        end
    endtask

    // Cacheline adaptor model, reset with the arbiter.
    task automatic adaptor();
        forever begin
            @(posedge clk);
            #1;
            bus.m_resp = 1'b0;
            if (rst !== 1'b1) begin
                mcnt = 0;
            end else if (spur_req != spur_done) begin
                spur_done   = spur_req;
                bus.m_resp  = 1'b1;
                bus.m_rdata = {(LW/8){8'h3C}};
            end else if (bus.m_read || bus.m_write) begin
                mcnt++;
                if (mcnt >= mem_lat) begin
                    bus.m_resp  = 1'b1;
                    bus.m_rdata = line_for(bus.m_addr);
                    mcnt        = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    endtask

    task automatic mon_one(input owner_e w, input logic [LW-1:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got owner %0d with no transaction expected", w);
        end else begin
            e = exp_q.pop_front();
            chk("resp_owner", LW'(w), LW'(e.who));
            chk("resp_data", data, e.data);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a resp strobe appears.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (bus.i_resp === 1'b1) mon_one(OWN_I, bus.i_rdata);
                if (bus.d_resp === 1'b1) mon_one(OWN_D, bus.d_rdata);
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        mem_lat     = 1;
        mcnt        = 0;
        spur_req    = 0;
        spur_done   = 0;
        w1          = {(LW/32){32'hDEAD_0001}};
        w2          = {(LW/32){32'hBEEF_0002}};
        rst         = 1'b0;
        bus.i_read  = 1'b0;
        bus.i_addr  = '0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.m_rdata = '0;
        bus.m_resp  = 1'b0;

        fork
            adaptor();
            monitor();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_read",  LW'(bus.m_read),  '0);
        chk("rst_m_write", LW'(bus.m_write), '0);
        chk("rst_m_addr",  LW'(bus.m_addr),  '0);
        chk("rst_m_wdata", bus.m_wdata,      '0);
        chk("rst_igrant",  LW'(cnt_igrant),  '0);
        chk("rst_dgrant",  LW'(cnt_dgrant),  '0);
        chk("rst_wait",    LW'(cnt_wait),    '0);
        rst = 1'b1;

        // Lone icache read, adaptor answers in cycle 5
        mem_lat = 5;
        tick();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0060;
        push(OWN_I, 32'h0000_0060);
        tick();
        @(negedge clk);
        chk("t1_m_read",  LW'(bus.m_read),  LW'(1));
        chk("t1_m_write", LW'(bus.m_write), '0);
        chk("t1_m_addr",  LW'(bus.m_addr),  LW'(32'h60));
        chk("t1_igrant",  LW'(cnt_igrant),  LW'(1));
        wait_resp(1'b0, n);
        chk("t1_resp_cycle", LW'(n), LW'(4));
        chk("t1_d_resp",     LW'(bus.d_resp), '0);
        tick();
        bus.i_read = 1'b0;
        @(negedge clk);
        chk("t1_m_read_low", LW'(bus.m_read), '0);
        chk("t1_igrant_end", LW'(cnt_igrant), LW'(1));

        // First tie after reset: D write wins, I waits
        mem_lat = 3;
        tick();
        bus.i_read  = 1'b1;
        bus.i_addr  = 32'h0000_0080;
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h0000_0100;
        bus.d_wdata = w1;
        push(OWN_D, 32'h0000_0100);
        push(OWN_I, 32'h0000_0080);
        tick();
        bus.d_addr  = 32'h0000_0200;
        bus.d_wdata = w2;
        @(negedge clk);
        chk("t2_m_write", LW'(bus.m_write), LW'(1));
        chk("t2_m_read",  LW'(bus.m_read),  '0);
        chk("t2_m_addr",  LW'(bus.m_addr),  LW'(32'h100));
        chk("t2_m_wdata", bus.m_wdata,      w1);
        chk("t2_dgrant",  LW'(cnt_dgrant),  LW'(1));
        chk("t2_wait_tie", LW'(cnt_wait),   LW'(1));
        wait_resp(1'b1, n);
        chk("t2_d_resp_cycle", LW'(n),          LW'(2));
        chk("t2_m_addr_held",  LW'(bus.m_addr), LW'(32'h100));
        chk("t2_m_wdata_held", bus.m_wdata,     w1);
        chk("t2_wait_mid",     LW'(cnt_wait),   LW'(3));
        tick();
        bus.d_write = 1'b0;
        bus.d_addr  = '0;
        @(negedge clk);
        chk("t2_m_write_low", LW'(bus.m_write), '0);
        chk("t2_m_read_gap",  LW'(bus.m_read),  '0);
        chk("t2_wait_after",  LW'(cnt_wait),    LW'(4));
        wait_resp(1'b0, n);
        chk("t2_i_resp_cycle", LW'(n), LW'(3));
        tick();
        bus.i_read = 1'b0;
        @(negedge clk);
        chk("t2_igrant", LW'(cnt_igrant), LW'(2));
        chk("t2_dgrant_end", LW'(cnt_dgrant), LW'(1));
        chk("t2_wait_end", LW'(cnt_wait), LW'(4));

        // Lone dcache read at minimum latency
        mem_lat = 1;
        tick();
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_0140;
        push(OWN_D, 32'h0000_0140);
        wait_resp(1'b1, n);
        chk("t3_min_latency", LW'(n), LW'(2));
        tick();
        bus.d_read = 1'b0;

        // Tie after a D grant goes to I
        mem_lat = 2;
        tick();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_00C0;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_0180;
        push(OWN_I, 32'h0000_00C0);
        push(OWN_D, 32'h0000_0180);
        tick();
        @(negedge clk);
        chk("t4_m_read", LW'(bus.m_read), LW'(1));
        chk("t4_m_addr", LW'(bus.m_addr), LW'(32'hC0));
        wait_resp(1'b0, n);
        chk("t4_i_resp_cycle", LW'(n), LW'(1));
        tick();
        bus.i_read = 1'b0;
        wait_resp(1'b1, n);
        chk("t4_d_resp_cycle", LW'(n), LW'(3));
        tick();
        bus.d_read = 1'b0;
        @(negedge clk);
        chk("t4_wait",   LW'(cnt_wait),   LW'(7));
        chk("t4_igrant", LW'(cnt_igrant), LW'(3));
        chk("t4_dgrant", LW'(cnt_dgrant), LW'(3));

        // Spurious m_resp while idle
        tick();
        spur_req++;
        repeat (3) @(negedge clk);
        chk("t5_m_read",  LW'(bus.m_read),  '0);
        chk("t5_m_write", LW'(bus.m_write), '0);
        chk("t5_igrant",  LW'(cnt_igrant),  LW'(3));
        mem_lat = 1;
        tick();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0040;
        push(OWN_I, 32'h0000_0040);
        tick();
        @(negedge clk);
        chk("t5_regrant_m_read", LW'(bus.m_read), LW'(1));
        chk("t5_regrant_m_addr", LW'(bus.m_addr), LW'(32'h40));
        chk("t5_regrant_i_resp", LW'(bus.i_resp), LW'(1));
        tick();
        bus.i_read = 1'b0;

        // Reset asserted during SERVE_D with an icache read pending
        mem_lat = 10;
        tick();
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h0000_01C0;
        bus.d_wdata = w2;
        bus.i_read  = 1'b1;
        bus.i_addr  = 32'h0000_00E0;
        push(OWN_I, 32'h0000_00E0);
        tick();
        @(negedge clk);
        chk("t6_m_write", LW'(bus.m_write), LW'(1));
        chk("t6_m_addr",  LW'(bus.m_addr),  LW'(32'h1C0));
        chk("t6_wait",    LW'(cnt_wait),    LW'(8));
        #2;
        rst         = 1'b0;
        bus.d_write = 1'b0;
        mem_lat     = 2;
        #1;
        chk("t6_rst_m_write", LW'(bus.m_write), '0);
        chk("t6_rst_m_addr",  LW'(bus.m_addr),  '0);
        chk("t6_rst_m_wdata", bus.m_wdata,      '0);
        chk("t6_rst_igrant",  LW'(cnt_igrant),  '0);
        chk("t6_rst_dgrant",  LW'(cnt_dgrant),  '0);
        chk("t6_rst_wait",    LW'(cnt_wait),    '0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_post_m_read", LW'(bus.m_read), LW'(1));
        chk("t6_post_m_addr", LW'(bus.m_addr), LW'(32'hE0));
        chk("t6_post_igrant", LW'(cnt_igrant), LW'(1));
        chk("t6_post_wait",   LW'(cnt_wait),   '0);
        wait_resp(1'b0, n);
        chk("t6_post_resp_cycle", LW'(n), LW'(1));
        tick();
        bus.i_read = 1'b0;

        // Grant counter saturation
        mem_lat = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.i_read = 1'b1;
            bus.i_addr = AW'(32'h0000_1000 + 32'(i) * 32'h20);
            push(OWN_I, bus.i_addr);
            wait_resp(1'b0, n);
            tick();
            bus.i_read = 1'b0;
        end
        @(negedge clk);
        chk("t7_igrant_sat", LW'(cnt_igrant), LW'(15));
        chk("t7_dgrant",     LW'(cnt_dgrant), '0);
        chk("t7_wait",       LW'(cnt_wait),   '0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", LW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Shares the single cacheline-granularity physical memory port between the instruction cache and the data cache of the mp4 pipelined core. Sits between the two caches and the cacheline adaptor that drives the burst `pmem_*` port. Grants one 256-bit line transaction at a time with round-robin fairness and holds the downstream request stable until memory responds. Keeps saturating performance counters for grants and contention stalls.

## Interface
- `LINE_W`, 256: cacheline width in bits.
- `ADDR_W`, 32: byte address width; line-aligned addresses are passed through unchanged.
- `CNT_W`, 32: performance counter width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_read`  in  1  icache line read request; held until `i_resp`.
- `i_addr`  in  ADDR_W  icache line address.
- `i_rdata`  out  LINE_W  line returned to icache.
- `i_resp`  out  1  icache transaction complete, one cycle.
- `d_read`  in  1  dcache line read request; held until `d_resp`.
- `d_write`  in  1  dcache line writeback request; held until `d_resp`.
- `d_addr`  in  ADDR_W  dcache line address.
- `d_wdata`  in  LINE_W  dcache writeback line.
- `d_rdata`  out  LINE_W  line returned to dcache.
- `d_resp`  out  1  dcache transaction complete, one cycle.
- `m_read`  out  1  read request to cacheline adaptor (registered).
- `m_write`  out  1  write request to cacheline adaptor (registered).
- `m_addr`  out  ADDR_W  latched request address (registered).
- `m_wdata`  out  LINE_W  latched write line (registered).
- `m_rdata`  in  LINE_W  line from adaptor, valid with `m_resp`.
- `m_resp`  in  1  adaptor transaction complete, one cycle.
- `cnt_igrant`, `cnt_dgrant`, `cnt_wait`  out  CNT_W each  saturating counters: icache grants, dcache grants, contention cycles.

## Operation
- States: `IDLE`, `SERVE_I`, `SERVE_D`. Reset state `IDLE`; `last_grant` resets to I.
- IDLE: if exactly one cache requests, grant it. If both request, grant the one not equal to `last_grant` (first conflict after reset goes to D). No request: stay.
- On grant edge: latch address (and `d_wdata` for writes) into `m_addr`/`m_wdata`, assert `m_read` or `m_write`, update `last_grant`, increment matching grant counter, move to `SERVE_I`/`SERVE_D`.
- `d_read` and `d_write` both high: treated as write.
- SERVE_x: hold all `m_*` outputs constant; requester inputs ignored. On `m_resp`: drive owner's `x_resp`=1 that cycle; at edge clear `m_read`/`m_write`, return to IDLE.
- `i_rdata` and `d_rdata` both combinationally equal `m_rdata`; only `x_resp` is gated by ownership.
- Requester dropping its request mid-transaction: downstream transaction still completes; its resp pulse is still issued.
- `m_resp` in IDLE: ignored; no resp output.
- `cnt_wait` increments each cycle a cache requests while the arbiter is not in IDLE serving nothing and that cache is not owner (i.e. request pending while other cache owns the port, or loses a tie). Counters saturate at all-ones, never wrap.

## Timing
- Reset values: all outputs 0, `m_addr`/`m_wdata` 0, counters 0. Reset mid-transaction clears immediately (asynchronous); adaptor is reset in the same domain.
- Arbitration latency: request seen in IDLE in cycle 0 → `m_read`/`m_write` high from cycle 1.
- Response: `x_resp` combinational with `m_resp` in cycle k; `m_read`/`m_write` low in cycle k+1; next grant earliest registered in cycle k+1, visible in cycle k+2.
- Minimum request-to-resp: 2 cycles (adaptor responding in the first cycle it sees the request).
- Caches deassert requests combinationally after their resp edge; IDLE in cycle k+1 therefore never re-grants a completed request.

## Structure
- Package `arbiter_types`: state enum (`ARB_IDLE`, `ARB_SERVE_I`, `ARB_SERVE_D`), owner enum (`OWN_I`, `OWN_D`), `LINE_W` default constant.
- Sub-module `sat_counter` (parameter width, inputs `clk`, `rst`, `inc`; output count), instantiated three times.

## Test plan
- Lone icache read at 0x0000_0060, adaptor responds after 4 cycles with line 0xAA..AA → `m_read`=1 cycle 1, `m_addr`=0x60, `i_resp`=1 with `i_rdata`=0xAA..AA in cycle 5, `d_resp` stays 0, `cnt_igrant`=1.
- I read and D write asserted same cycle after reset → D served first (`m_write`=1, `m_wdata`=`d_wdata`), I then served; `cnt_wait` counts I's waiting cycles; next tie grants I.
- Requester changes `d_addr` from 0x100 to 0x200 mid-transaction → `m_addr` stays 0x100 until `m_resp`.
- Spurious `m_resp` in IDLE → no `i_resp`/`d_resp`, state stays IDLE.
- Assert reset during SERVE_D → `m_write` and all counters 0 immediately; after release a pending `i_read` is granted.
- Force counter width 4, issue 20 icache reads → `cnt_igrant` saturates at 15.
